// File: rtl/dual_update_seq.sv
// Sequencer for one ADMM dual-update pass over the horizon, with primal-residual tracking.
//   state  | meaning
//   IDLE   | waiting for go
//   READ   | knot memory read, MEM_LAT cycles (rd_en on first)
//   FIRE   | du_start pulse, residual of knot k folded into running max
//   WAIT   | waiting for du_done
//   WRITE  | write-back strobes, advance k
//   FINISH | pass_done pulse, results registered on entry
module dual_update_seq #(
    parameter int STATE_DIM   = 12,
    parameter int CONTROL_DIM = 4,
    parameter int W           = 16,
    parameter int HORIZON     = 10,
    parameter int MEM_LAT     = 1,
    parameter int KW          = (HORIZON > 1) ? $clog2(HORIZON) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            go,
    input  logic                            clr_iter,
    input  logic [W-1:0]                    tol,
    input  logic [CONTROL_DIM-1:0][W-1:0]   u_k,
    input  logic [CONTROL_DIM-1:0][W-1:0]   z_k,
    input  logic [STATE_DIM-1:0][W-1:0]     x_k,
    input  logic [STATE_DIM-1:0][W-1:0]     v_k,
    input  logic                            du_done,
    output logic                            rd_en,
    output logic [KW-1:0]                   rd_addr,
    output logic                            du_start,
    output logic                            wr_en,
    output logic                            wr_ctrl_en,
    output logic [KW-1:0]                   wr_addr,
    output logic                            busy,
    output logic                            pass_done,
    output logic [W-1:0]                    prim_res,
    output logic                            converged,
    output logic [7:0]                      iter_cnt
);

    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [KW-1:0] K_LAST  = KW'(HORIZON - 1);
    localparam logic [LW-1:0] LAT_TOP = LW'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_FIRE, S_WAIT, S_WRITE, S_FINISH
    } state_t;

    state_t          state, state_nx;
    logic [KW-1:0]   k;
    logic [LW-1:0]   lat_cnt;
    logic [W-1:0]    run_max;
    logic [W-1:0]    knot_max;
    logic            last_knot;

    assign last_knot = (k == K_LAST);
    assign rd_addr   = k;
    assign wr_addr   = k;

    // |a - b| in W+1 bits; the result is clamped to all-ones if it ever exceeds W bits.
    function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        logic [W:0] mag;
        d   = {a[W-1], a} - {b[W-1], b};
        mag = d[W] ? (~d + (W+1)'(1)) : d;
        return mag[W] ? {W{1'b1}} : mag[W-1:0];
    endfunction

    always_comb begin
        logic [W-1:0] m;
        knot_max = '0;
        for (int i = 0; i < STATE_DIM; i++) begin
            m = abs_diff(x_k[i], v_k[i]);
            if (m > knot_max) knot_max = m;
        end
        if (!last_knot) begin
            for (int i = 0; i < CONTROL_DIM; i++) begin
                m = abs_diff(u_k[i], z_k[i]);
                if (m > knot_max) knot_max = m;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        rd_en      = 1'b0;
        du_start   = 1'b0;
        wr_en      = 1'b0;
        wr_ctrl_en = 1'b0;
        pass_done  = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE:   if (go) state_nx = S_READ;
            S_READ: begin
                rd_en = (lat_cnt == LAT_TOP);
                if (lat_cnt == '0) state_nx = S_FIRE;
            end
            S_FIRE: begin
                du_start = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT:   if (du_done) state_nx = S_WRITE;
            S_WRITE: begin
                wr_en      = 1'b1;
                wr_ctrl_en = !last_knot;
                state_nx   = last_knot ? S_FINISH : S_READ;
            end
            S_FINISH: begin
                pass_done = 1'b1;
                state_nx  = S_IDLE;
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k         <= '0;
            lat_cnt   <= '0;
            run_max   <= '0;
            prim_res  <= '0;
            converged <= 1'b0;
            iter_cnt  <= '0;
        end else begin
            if (state == S_IDLE && go) begin
                k       <= '0;
                run_max <= '0;
            end
            if (state_nx == S_READ && state != S_READ)
                lat_cnt <= LAT_TOP;
            else if (state == S_READ && lat_cnt != '0)
                lat_cnt <= lat_cnt - 1'b1;
            if (state == S_FIRE && knot_max > run_max)
                run_max <= knot_max;
            if (state == S_WRITE && !last_knot)
                k <= k + 1'b1;
            // Results land on the edge into FINISH so they appear alongside pass_done.
            if (state == S_WRITE && last_knot) begin
                prim_res  <= run_max;
                converged <= (run_max <= tol);
            end
            if (clr_iter)
                iter_cnt <= '0;
            else if (state == S_WRITE && last_knot && iter_cnt != 8'hFF)
                iter_cnt <= iter_cnt + 8'd1;
        end
    end

endmodule
